// File: rtl/pc_sequencer.sv
// Next-PC generation with latched Z/C flags and a hardware return-address stack.
// Optional macro PC_SEQ_ERROR_HALT_EN: a sticky stack error freezes the PC and all state.
module pc_sequencer #(
  parameter int PC_WIDTH    = 12,
  parameter int STACK_DEPTH = 8,
  parameter int SP_WIDTH    = $clog2(STACK_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] current_pc,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                jump,
  input  logic                br_z,
  input  logic                br_nz,
  input  logic                br_c,
  input  logic                br_nc,
  input  logic                call,
  input  logic                ret,
  input  logic                flag_we,
  input  logic                zero_in,
  input  logic                cout_in,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                zero_flag,
  output logic                carry_flag,
  output logic [SP_WIDTH-1:0] sp,
  output logic                stack_overflow,
  output logic                stack_underflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [SP_WIDTH-1:0] SP_FULL = SP_WIDTH'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] ras_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] ras_d [STACK_DEPTH];
  logic [SP_WIDTH-1:0] sp_q, sp_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    top_idx;
  logic                sp_empty;
  logic                sp_full;
  logic                br_taken;
  logic                halt;

`ifdef PC_SEQ_ERROR_HALT_EN
  assign halt = ovf_q | unf_q;
`else
  assign halt = 1'b0;
`endif

  assign pc_inc   = current_pc + PC_WIDTH'(1);
  assign push_idx = sp_q[IDX_W-1:0];
  // With sp == STACK_DEPTH the low bits are zero, so the decrement wraps to the last entry.
  assign top_idx  = sp_q[IDX_W-1:0] - IDX_W'(1);
  assign sp_empty = (sp_q == '0);
  assign sp_full  = (sp_q == SP_FULL);
  assign br_taken = (br_z & zero_q) | (br_nz & ~zero_q) | (br_c & carry_q) | (br_nc & ~carry_q);

  // During reset the pc register reloads itself; only the increment path is offered.
  always_comb begin
    next_pc = pc_inc;
    if (rst) begin
      next_pc = pc_inc;
    end else if (halt) begin
      next_pc = current_pc;
    end else if (ret) begin
      next_pc = sp_empty ? pc_inc : ras_q[top_idx];
    end else if (call || jump || br_taken) begin
      next_pc = target;
    end
  end

  always_comb begin
    ras_d   = ras_q;
    sp_d    = sp_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!halt) begin
      if (flag_we) begin
        zero_d  = zero_in;
        carry_d = cout_in;
      end
      // ret takes precedence; a simultaneous call is dropped entirely.
      if (ret) begin
        if (sp_empty) unf_d = 1'b1;
        else          sp_d  = sp_q - SP_WIDTH'(1);
      end else if (call) begin
        if (sp_full) begin
          ovf_d = 1'b1;
        end else begin
          ras_d[push_idx] = pc_inc;
          sp_d            = sp_q + SP_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) ras_q[i] <= '0;
      sp_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ras_q   <= ras_d;
      sp_q    <= sp_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign zero_flag       = zero_q;
  assign carry_flag      = carry_q;
  assign sp              = sp_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: flag timing, call/ret, overflow/underflow, conflict, halt.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [11:0] current_pc;
  logic [11:0] target;
  logic        jump, br_z, br_nz, br_c, br_nc, call, ret;
  logic        flag_we, zero_in, cout_in;
  logic [11:0] next_pc;
  logic        zero_flag, carry_flag;
  logic [3:0]  sp;
  logic        stack_overflow, stack_underflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_pc;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .current_pc(current_pc), .target(target),
    .jump(jump), .br_z(br_z), .br_nz(br_nz), .br_c(br_c), .br_nc(br_nc),
    .call(call), .ret(ret), .flag_we(flag_we), .zero_in(zero_in), .cout_in(cout_in),
    .next_pc(next_pc), .zero_flag(zero_flag), .carry_flag(carry_flag), .sp(sp),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_strobes();
    jump = 0; br_z = 0; br_nz = 0; br_c = 0; br_nc = 0;
    call = 0; ret = 0; flag_we = 0; zero_in = 0; cout_in = 0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_strobes();
    rst = 1; current_pc = 12'h000; target = 12'h000;
    tick();
    check_eq("rst_sp", sp, 0);
    check_eq("rst_flags", {zero_flag, carry_flag}, 0);
    check_eq("rst_errs", {stack_overflow, stack_underflow}, 0);
    check_eq("rst_npc", next_pc, 12'h001);
    current_pc = 12'hFFF; #1;
    check_eq("rst_wrap", next_pc, 12'h000);
    rst = 0;

    // Same-cycle flag_we must not affect the branch decision.
    flag_we = 1; zero_in = 1; br_z = 1; target = 12'h080; current_pc = 12'h010; #1;
    check_eq("flag_same_cycle", next_pc, 12'h011);
    tick();
    clear_strobes();
    check_eq("zero_latched", zero_flag, 1);
    br_z = 1; current_pc = 12'h011; #1;
    check_eq("br_z_taken", next_pc, 12'h080);
    br_z = 0; br_nz = 1; #1;
    check_eq("br_nz_not", next_pc, 12'h012);
    br_nz = 0; flag_we = 1; cout_in = 1;
    tick();
    clear_strobes();
    check_eq("carry_latched", {zero_flag, carry_flag}, 2'b01);
    br_c = 1; target = 12'h0C0; #1;
    check_eq("br_c_taken", next_pc, 12'h0C0);
    br_c = 0; br_nc = 1; #1;
    check_eq("br_nc_not", next_pc, 12'h012);
    br_nc = 0; jump = 1; target = 12'h3AB; #1;
    check_eq("jump", next_pc, 12'h3AB);
    jump = 0;

    // Call then ret.
    call = 1; target = 12'h200; current_pc = 12'h034; #1;
    check_eq("call_npc", next_pc, 12'h200);
    tick();
    call = 0;
    check_eq("call_sp", sp, 1);
    ret = 1; current_pc = 12'h200; #1;
    check_eq("ret_npc", next_pc, 12'h035);
    tick();
    ret = 0;
    check_eq("ret_sp", sp, 0);

    // Nine calls: eight pushes, the ninth overflows but still jumps.
    for (int i = 0; i < 9; i++) begin
      call = 1; target = 12'h300; current_pc = 12'h100 + 12'(i); #1;
      check_eq("nest_call_npc", next_pc, 12'h300);
      if (i < 8) exp_q.push_back(12'h101 + 12'(i));
      tick();
    end
    call = 0;
    check_eq("nest_sp", sp, 8);
    check_eq("nest_ovf", stack_overflow, 1);
`ifdef PC_SEQ_ERROR_HALT_EN
    jump = 1; target = 12'h555; current_pc = 12'h300; #1;
    check_eq("ovf_halt_npc", next_pc, 12'h300);
    tick();
    jump = 0;
    check_eq("ovf_halt_sp", sp, 8);
    exp_q.delete();
`else
    current_pc = 12'h300;
    while (exp_q.size() > 0) begin
      exp_pc = exp_q.pop_back();
      ret = 1; #1;
      check_eq("pop_npc", next_pc, 32'(exp_pc));
      tick();
    end
    ret = 0;
    check_eq("pop_sp", sp, 0);
`endif

    rst = 1;
    tick();
    rst = 0;
    check_eq("rst2_errs", {stack_overflow, stack_underflow}, 0);

    // call+ret with two entries: pop only.
    for (int i = 0; i < 2; i++) begin
      call = 1; target = 12'h300; current_pc = 12'h400 + 12'(i);
      tick();
    end
    call = 1; ret = 1; target = 12'h600; current_pc = 12'h500; #1;
    check_eq("conflict_npc", next_pc, 12'h402);
    tick();
    call = 0;
    check_eq("conflict_sp", sp, 1);
    #1;
    check_eq("conflict_next_top", next_pc, 12'h401);
    tick();
    ret = 0;
    check_eq("conflict_drain_sp", sp, 0);

    // Underflow.
    ret = 1; current_pc = 12'h050; #1;
    check_eq("unf_npc", next_pc, 12'h051);
    tick();
    ret = 0;
    check_eq("unf_flag", stack_underflow, 1);
    check_eq("unf_sp", sp, 0);
    jump = 1; target = 12'h777; current_pc = 12'h051; #1;
`ifdef PC_SEQ_ERROR_HALT_EN
    check_eq("halt_npc", next_pc, 12'h051);
`else
    check_eq("nohalt_npc", next_pc, 12'h777);
`endif
    call = 1; jump = 0;
    tick();
    call = 0;
`ifdef PC_SEQ_ERROR_HALT_EN
    check_eq("halt_sp_held", sp, 0);
`else
    check_eq("nohalt_push_sp", sp, 1);
`endif
    check_eq("unf_sticky", stack_underflow, 1);

    rst = 1;
    tick();
    rst = 0;
    check_eq("rst3_errs", {stack_overflow, stack_underflow}, 0);
    jump = 1; target = 12'h777; #1;
    check_eq("resume_npc", next_pc, 12'h777);
    jump = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC generation stage, directly upstream of the program-counter register in the single-cycle processor.
- Consumes controller decode strobes, ALU zero/carry outputs and the 12-bit instruction target field.
- Produces next_pc for the pc register, and holds the latched condition flags plus a hardware return-address stack (RAS) for call/return.
- next_pc is combinational from current state and inputs; flags, RAS and stack pointer are sequential.

Parameters:
- PC_WIDTH, 12: width of current_pc, target and next_pc.
- STACK_DEPTH, 8: number of RAS entries; power of two, >= 2.
- SP_WIDTH, $clog2(STACK_DEPTH)+1: stack-pointer width, so that 0..STACK_DEPTH is representable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- current_pc  input  PC_WIDTH  output of the pc register.
- target  input  PC_WIDTH  absolute jump/branch/call target (instruction[11:0]).
- jump  input  1  unconditional jump.
- br_z, br_nz, br_c, br_nc  input  1 each  branch if zero / not zero / carry / not carry.
- call  input  1  push return address and jump.
- ret  input  1  pop return address.
- flag_we  input  1  latch zero_in/cout_in at this edge.
- zero_in  input  1  ALU zero.
- cout_in  input  1  ALU carry out.
- next_pc  output  PC_WIDTH  value loaded into the pc register.
- zero_flag  output  1  latched Z.
- carry_flag  output  1  latched C.
- sp  output  SP_WIDTH  current stack depth.
- stack_overflow  output  1  sticky error flag.
- stack_underflow  output  1  sticky error flag.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset state at the first clk edge with rst=1: zero_flag=0, carry_flag=0, sp=0, stack_overflow=0, stack_underflow=0, all RAS entries=0. During reset, next_pc = current_pc+1; the pc register handles its own reset.
- pc_inc = current_pc + 1, modulo 2^PC_WIDTH; 4095 wraps to 0.
- next_pc priority, highest first:
  - ret: RAS[sp-1] if sp>0, else pc_inc.
  - call: target.
  - jump: target.
  - Taken branch: target. Taken means br_z&zero_flag, br_nz&~zero_flag, br_c&carry_flag or br_nc&~carry_flag; any taken branch selects target.
  - Otherwise pc_inc.
- Branches test the registered flags, i.e. the values latched by the most recent earlier flag_we. A flag_we in the same cycle does not affect that cycle's branch decision; the new flags are visible from the next cycle.
- Flags: on a clk edge with flag_we=1, zero_flag<=zero_in and carry_flag<=cout_in. Otherwise hold.
- Call, only when ret=0:
  - sp<STACK_DEPTH: RAS[sp]<=pc_inc, sp<=sp+1.
  - sp==STACK_DEPTH: no write, sp holds, stack_overflow<=1; the jump to target still occurs.
- Ret:
  - sp>0: sp<=sp-1.
  - sp==0: sp holds, stack_underflow<=1, next_pc=pc_inc.
- Simultaneous call and ret: ret wins, call is fully ignored, no push.
- Sticky error flags clear only on rst.
- rst asserted in the same cycle as call/ret/flag_we: reset wins, no push/pop/flag update.
- No internal latency beyond the state update: a push at edge N is poppable by a ret in cycle N+1.

Optional Feature:
- Macro: PC_SEQ_ERROR_HALT_EN.
- Defined: while stack_overflow or stack_underflow is 1, next_pc = current_pc (processor halts) regardless of strobes, and RAS/sp/flags hold. The cycle that detects the error still follows the normal rules; the halt starts the following cycle.
- Undefined: errors are recorded only; sequencing continues as specified above.

Test Plan:
- Reset then idle: rst=1 for 1 cycle, current_pc=12'h000 -> sp=0, flags=0, errors=0, next_pc=12'h001; current_pc=12'hFFF -> next_pc=12'h000.
- Flag timing: flag_we=1, zero_in=1, br_z=1, target=12'h080, current_pc=12'h010 -> next_pc=12'h011 that cycle. Next cycle br_z=1, current_pc=12'h011 -> next_pc=12'h080; br_nz=1 -> 12'h012.
- Call/ret: call, target=12'h200, current_pc=12'h034 -> next_pc=12'h200, sp=1. Later ret -> next_pc=12'h035, sp=0.
- Nesting/overflow: 9 calls from pcs 12'h100..12'h108 -> sp=8, stack_overflow=1 after the 9th, 9th call still jumps. 8 rets -> next_pc 12'h108,12'h107,...,12'h101 (8 pops, 9th return address dropped), sp=0.
- Underflow and call+ret conflict:
  - ret with sp=0, current_pc=12'h050 -> next_pc=12'h051, stack_underflow=1.
  - call&ret with sp=2 -> pop top entry, sp=1, no push.
- Halt (PC_SEQ_ERROR_HALT_EN defined): after the underflow above, current_pc=12'h051 with jump=1 -> next_pc=12'h051, sp held. rst -> errors clear and sequencing resumes.
